// File: rtl/risc_regfile_arbiter_pkg.sv
// Shared types and constants for the register-file arbiter and its sub-module.
package risc_regfile_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  // Requester indices inside every 2-bit request/grant vector
  localparam logic CORE = 1'b0;
  localparam logic DBG  = 1'b1;

  typedef enum logic [1:0] {
    LOCK_NORMAL = 2'd0,
    LOCK_DRAIN  = 2'd1,
    LOCK_LOCKED = 2'd2
  } lock_state_e;

  // Pick one requester's register index out of a {debug, core} packed pair
  function automatic logic [REG_IDX_W-1:0] pick_idx(input logic [2*REG_IDX_W-1:0] vec,
                                                     input logic sel);
    return sel ? vec[2*REG_IDX_W-1:REG_IDX_W] : vec[REG_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/risc_regfile_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the requester that wins a tie.
module rr_arb2
  import risc_regfile_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       win
);

  logic ptr;

  // Grant the pointed requester on contention, otherwise whoever asks
  always_comb begin
    gnt = 2'b00;
    win = ptr;
    if (req == 2'b11) begin
      win = ptr;
      gnt = ptr ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      win = CORE;
      gnt = 2'b01;
    end else if (req[1]) begin
      win = DBG;
      gnt = 2'b10;
    end
  end

  // After any grant the other requester gets priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CORE;
    end else if (gnt != 2'b00) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/risc_regfile_arbiter.sv
// Arbitrates core and debug access to a 2R1W register file, with optional
// write-to-read forwarding and a debug exclusive-access lock.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// LOCK_NORMAL | core and debug both arbitrate
// LOCK_DRAIN  | core blocked, waiting for in-flight read response to clear
// LOCK_LOCKED | core blocked, debug owns the register file, ack high
module risc_regfile_arbiter
  import risc_regfile_arbiter_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               rd_valid,
  output logic [1:0]               rd_ready,
  input  logic [2*REG_IDX_W-1:0]   rd_rs1,
  input  logic [2*REG_IDX_W-1:0]   rd_rs2,
  input  logic [1:0]               wr_valid,
  output logic [1:0]               wr_ready,
  input  logic [2*REG_IDX_W-1:0]   wr_rd,
  input  logic [2*XLEN-1:0]        wr_data,
  output logic                     rsp_valid,
  output logic                     rsp_id,
  output logic [XLEN-1:0]          rsp_rs1_data,
  output logic [XLEN-1:0]          rsp_rs2_data,
  input  logic                     dbg_lock,
  output logic                     dbg_lock_ack,
  output logic [REG_IDX_W-1:0]     rf_rs1,
  output logic [REG_IDX_W-1:0]     rf_rs2,
  output logic [REG_IDX_W-1:0]     rf_rd,
  output logic                     rf_read_enable,
  output logic                     rf_write_enable,
  output logic [XLEN-1:0]          rf_rd_data,
  input  logic [XLEN-1:0]          rf_rs1_data,
  input  logic [XLEN-1:0]          rf_rs2_data
);

  lock_state_e state_q, state_d;
  logic        core_ok;

  logic [1:0]  rd_req, wr_req, rd_gnt, wr_gnt;
  logic        rd_win, wr_win, rd_fire, wr_fire;

  logic [REG_IDX_W-1:0] rs1_sel, rs2_sel, rd_sel;
  logic [XLEN-1:0]      wdata_sel;
  logic                 byp1, byp2;

  logic                 rsp_valid_q, rsp_id_q;
  logic                 zero1_q, zero2_q, byp1_q, byp2_q;
  logic [XLEN-1:0]      byp_data_q;

  // Core is masked outside NORMAL; nothing is granted while reset is held
  assign rd_req = rd_valid & {1'b1, core_ok} & {2{rst_n}};
  assign wr_req = wr_valid & {1'b1, core_ok} & {2{rst_n}};

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .gnt   (rd_gnt),
    .win   (rd_win)
  );

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .gnt   (wr_gnt),
    .win   (wr_win)
  );

  assign rd_fire   = (rd_gnt != 2'b00);
  assign wr_fire   = (wr_gnt != 2'b00);
  assign rs1_sel   = pick_idx(rd_rs1, rd_win);
  assign rs2_sel   = pick_idx(rd_rs2, rd_win);
  assign rd_sel    = pick_idx(wr_rd, wr_win);
  assign wdata_sel = wr_win ? wr_data[2*XLEN-1:XLEN] : wr_data[XLEN-1:0];

  assign rd_ready        = rd_gnt;
  assign wr_ready        = wr_gnt;
  assign rf_rs1          = rs1_sel;
  assign rf_rs2          = rs2_sel;
  assign rf_read_enable  = rd_fire;
  assign rf_rd           = rd_sel;
  assign rf_rd_data      = wdata_sel;
  // x0 writes are accepted but never reach the register file
  assign rf_write_enable = wr_fire && (rd_sel != '0);

  // Forward only when both transfers happen this cycle on the same nonzero index
  assign byp1 = (BYPASS != 0) && rd_fire && wr_fire && (rd_sel != '0) && (rd_sel == rs1_sel);
  assign byp2 = (BYPASS != 0) && rd_fire && wr_fire && (rd_sel != '0) && (rd_sel == rs2_sel);

  // Response tracking: one-cycle latency, aligned with register-file read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= CORE;
      zero1_q     <= 1'b0;
      zero2_q     <= 1'b0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_fire;
      if (rd_fire) begin
        rsp_id_q   <= rd_win;
        zero1_q    <= (rs1_sel == '0);
        zero2_q    <= (rs2_sel == '0);
        byp1_q     <= byp1;
        byp2_q     <= byp2;
        byp_data_q <= wdata_sel;
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_rs1_data = zero1_q ? '0 : (byp1_q ? byp_data_q : rf_rs1_data);
  assign rsp_rs2_data = zero2_q ? '0 : (byp2_q ? byp_data_q : rf_rs2_data);

  // Lock state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOCK_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock next-state and outputs; a read granted in DRAIN is still outstanding
  always_comb begin
    state_d      = state_q;
    core_ok      = 1'b0;
    dbg_lock_ack = 1'b0;
    unique case (state_q)
      LOCK_NORMAL: begin
        core_ok = 1'b1;
        if (dbg_lock) state_d = LOCK_DRAIN;
      end
      LOCK_DRAIN: begin
        if (!dbg_lock)    state_d = LOCK_NORMAL;
        else if (!rd_fire) state_d = LOCK_LOCKED;
      end
      LOCK_LOCKED: begin
        dbg_lock_ack = 1'b1;
        if (!dbg_lock) state_d = LOCK_NORMAL;
      end
      default: state_d = LOCK_NORMAL;
    endcase
  end

endmodule

// File: tb/tb_risc_regfile_arbiter.sv
// Self-checking bench: two DUTs (BYPASS=0 and BYPASS=1) share stimulus and are
// compared against a transaction-level model of the arbiter.
module tb_risc_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_valid, wr_valid;
  logic [9:0]  rd_rs1, rd_rs2, wr_rd;
  logic [63:0] wr_data;
  logic        dbg_lock;

  logic [1:0]  rd_ready [2];
  logic [1:0]  wr_ready [2];
  logic        rsp_valid [2];
  logic        rsp_id [2];
  logic [31:0] rsp_rs1_data [2];
  logic [31:0] rsp_rs2_data [2];
  logic        dbg_lock_ack [2];
  logic [4:0]  rf_rs1 [2];
  logic [4:0]  rf_rs2 [2];
  logic [4:0]  rf_rd [2];
  logic        rf_read_enable [2];
  logic        rf_write_enable [2];
  logic [31:0] rf_rd_data [2];
  logic [31:0] rf_rs1_data [2];
  logic [31:0] rf_rs2_data [2];

  always #5 clk = ~clk;

  risc_regfile_arbiter #(.BYPASS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready[0]), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .wr_valid(wr_valid), .wr_ready(wr_ready[0]), .wr_rd(wr_rd), .wr_data(wr_data),
    .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
    .rsp_rs1_data(rsp_rs1_data[0]), .rsp_rs2_data(rsp_rs2_data[0]),
    .dbg_lock(dbg_lock), .dbg_lock_ack(dbg_lock_ack[0]),
    .rf_rs1(rf_rs1[0]), .rf_rs2(rf_rs2[0]), .rf_rd(rf_rd[0]),
    .rf_read_enable(rf_read_enable[0]), .rf_write_enable(rf_write_enable[0]),
    .rf_rd_data(rf_rd_data[0]), .rf_rs1_data(rf_rs1_data[0]), .rf_rs2_data(rf_rs2_data[0])
  );

  risc_regfile_arbiter #(.BYPASS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready[1]), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .wr_valid(wr_valid), .wr_ready(wr_ready[1]), .wr_rd(wr_rd), .wr_data(wr_data),
    .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
    .rsp_rs1_data(rsp_rs1_data[1]), .rsp_rs2_data(rsp_rs2_data[1]),
    .dbg_lock(dbg_lock), .dbg_lock_ack(dbg_lock_ack[1]),
    .rf_rs1(rf_rs1[1]), .rf_rs2(rf_rs2[1]), .rf_rd(rf_rd[1]),
    .rf_read_enable(rf_read_enable[1]), .rf_write_enable(rf_write_enable[1]),
    .rf_rd_data(rf_rd_data[1]), .rf_rs1_data(rf_rs1_data[1]), .rf_rs2_data(rf_rs2_data[1])
  );

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 0) ? 32'hFFFF_FFFF : {b, 8'hA5, b, 8'h5A};
  endfunction

  // Behavioural register file per DUT, read data one cycle after the strobe
  logic [31:0] mem [2][32];
  for (genvar g = 0; g < 2; g++) begin : g_rf
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) mem[g][i] <= init_val(i);
        rf_rs1_data[g] <= 32'h0;
        rf_rs2_data[g] <= 32'h0;
      end else begin
        if (rf_read_enable[g]) begin
          rf_rs1_data[g] <= mem[g][rf_rs1[g]];
          rf_rs2_data[g] <= mem[g][rf_rs2[g]];
        end
        if (rf_write_enable[g]) mem[g][rf_rd[g]] <= rf_rd_data[g];
      end
    end
  end

  // Reference model state: architectural registers, priorities, lock mode
  int          n_chk = 0;
  int          n_err = 0;
  int          m_rprio, m_wprio, m_mode;  // mode 0 normal, 1 draining, 2 locked
  logic [31:0] m_regs [32];
  logic        p_valid, p_id;
  logic [31:0] p_d1 [2];
  logic [31:0] p_d2 [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit c, input bit d, input int prio);
    if (c && d) return prio;
    if (c) return 0;
    if (d) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_rprio = 0;
    m_wprio = 0;
    m_mode  = 0;
    p_valid = 1'b0;
    p_id    = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = init_val(i);
  endtask

  task automatic set_in(input logic [1:0] rv, input logic [9:0] r1, input logic [9:0] r2,
                        input logic [1:0] wv, input logic [9:0] wd, input logic [63:0] wdat,
                        input logic lk);
    rd_valid = rv; rd_rs1 = r1; rd_rs2 = r2;
    wr_valid = wv; wr_rd = wd; wr_data = wdat; dbg_lock = lk;
  endtask

  // One clock cycle: check at negedge, then advance the model past posedge
  task automatic step();
    int          rw, ww;
    logic [4:0]  s1, s2, wd;
    logic [31:0] wdat;
    logic        np_valid, np_id;
    logic [31:0] n1 [2];
    logic [31:0] n2 [2];
    @(negedge clk);
    rw = pick(rd_valid[0] && (m_mode == 0), rd_valid[1], m_rprio);
    ww = pick(wr_valid[0] && (m_mode == 0), wr_valid[1], m_wprio);
    s1 = (rw == 1) ? rd_rs1[9:5] : rd_rs1[4:0];
    s2 = (rw == 1) ? rd_rs2[9:5] : rd_rs2[4:0];
    wd = (ww == 1) ? wr_rd[9:5] : wr_rd[4:0];
    wdat = (ww == 1) ? wr_data[63:32] : wr_data[31:0];
    for (int b = 0; b < 2; b++) begin
      chk("rd_ready", rd_ready[b], (rw < 0) ? 2'b00 : (2'b01 << rw));
      chk("wr_ready", wr_ready[b], (ww < 0) ? 2'b00 : (2'b01 << ww));
      chk("rf_read_enable", rf_read_enable[b], rw >= 0);
      chk("rf_write_enable", rf_write_enable[b], (ww >= 0) && (wd != 0));
      chk("rsp_valid", rsp_valid[b], p_valid);
      chk("dbg_lock_ack", dbg_lock_ack[b], m_mode == 2);
      if (p_valid) begin
        chk("rsp_id", rsp_id[b], p_id);
        chk("rsp_rs1_data", rsp_rs1_data[b], p_d1[b]);
        chk("rsp_rs2_data", rsp_rs2_data[b], p_d2[b]);
      end
      if (rw >= 0) begin
        chk("rf_rs1", rf_rs1[b], s1);
        chk("rf_rs2", rf_rs2[b], s2);
      end
      if (ww >= 0 && wd != 0) begin
        chk("rf_rd", rf_rd[b], wd);
        chk("rf_rd_data", rf_rd_data[b], wdat);
      end
    end
    np_valid = (rw >= 0);
    np_id    = (rw == 1);
    for (int b = 0; b < 2; b++) begin
      n1[b] = (s1 == 0) ? 32'h0 : ((b == 1 && ww >= 0 && wd == s1) ? wdat : m_regs[s1]);
      n2[b] = (s2 == 0) ? 32'h0 : ((b == 1 && ww >= 0 && wd == s2) ? wdat : m_regs[s2]);
    end
    @(posedge clk);
    if (ww >= 0 && wd != 0) m_regs[wd] = wdat;
    if (rw >= 0) m_rprio = 1 - rw;
    if (ww >= 0) m_wprio = 1 - ww;
    case (m_mode)
      0: if (dbg_lock) m_mode = 1;
      1: if (!dbg_lock) m_mode = 0; else if (rw < 0) m_mode = 2;
      default: if (!dbg_lock) m_mode = 0;
    endcase
    p_valid = np_valid;
    p_id    = np_id;
    for (int b = 0; b < 2; b++) begin
      p_d1[b] = n1[b];
      p_d2[b] = n2[b];
    end
    #1;
  endtask

  // Hold reset with requests pending; everything must stay quiet
  task automatic do_reset();
    rst_n = 1'b0;
    set_in(2'b11, 10'h021, 10'h043, 2'b11, 10'h0A5, 64'h1111_1111_2222_2222, 1'b1);
    #2;
    for (int b = 0; b < 2; b++) begin
      chk("rst_rsp_valid", rsp_valid[b], 1'b0);
      chk("rst_rsp_id", rsp_id[b], 1'b0);
      chk("rst_ack", dbg_lock_ack[b], 1'b0);
      chk("rst_rd_en", rf_read_enable[b], 1'b0);
      chk("rst_wr_en", rf_write_enable[b], 1'b0);
    end
    @(posedge clk);
    #1;
    set_in(2'b00, 10'h0, 10'h0, 2'b00, 10'h0, 64'h0, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(2'b00, 10'h0, 10'h0, 2'b00, 10'h0, 64'h0, 1'b0);
    model_reset();
    #3;
    do_reset();
    step();

    // Read contention: core, debug, core, debug
    set_in(2'b11, {5'd2, 5'd1}, {5'd4, 5'd3}, 2'b00, 10'h0, 64'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", rd_ready[1], (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("rr_rsp_id", rsp_id[1], (i % 2 == 0) ? 1'b0 : 1'b1);
    end
    set_in(2'b00, 10'h0, 10'h0, 2'b00, 10'h0, 64'h0, 1'b0);
    step();

    // Core writes x5 while debug reads x5
    set_in(2'b10, {5'd5, 5'd0}, 10'h0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 1'b0);
    step();
    chk("bypass_on", rsp_rs1_data[1], 32'hDEADBEEF);
    chk("bypass_off", rsp_rs1_data[0], init_val(5));
    set_in(2'b01, {5'd0, 5'd5}, 10'h0, 2'b00, 10'h0, 64'h0, 1'b0);
    step();
    chk("x5_after_write", rsp_rs1_data[0], 32'hDEADBEEF);

    // x0 write is swallowed, x0 reads as zero
    set_in(2'b00, 10'h0, 10'h0, 2'b01, 10'h0, {32'h0, 32'h1234}, 1'b0);
    #1;
    chk("x0_wr_en", rf_write_enable[1], 1'b0);
    chk("x0_wr_ready", wr_ready[1], 2'b01);
    step();
    set_in(2'b01, 10'h0, 10'h0, 2'b00, 10'h0, 64'h0, 1'b0);
    step();
    chk("x0_read", rsp_rs1_data[1], 32'h0);
    chk("x0_read_nb", rsp_rs1_data[0], 32'h0);

    // Lock raised in a core-read grant cycle
    set_in(2'b01, {5'd0, 5'd7}, 10'h0, 2'b00, 10'h0, 64'h0, 1'b1);
    #1;
    chk("lock_core_grant", rd_ready[1], 2'b01);
    step();
    chk("lock_rsp", rsp_valid[1], 1'b1);
    set_in(2'b01, {5'd0, 5'd8}, 10'h0, 2'b00, 10'h0, 64'h0, 1'b1);
    #1;
    chk("drain_stall", rd_ready[1], 2'b00);
    chk("drain_ack", dbg_lock_ack[1], 1'b0);
    step();
    chk("lock_ack", dbg_lock_ack[1], 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_in(2'b01, {5'd0, 5'd8}, 10'h0, 2'b10, {5'd9, 5'd0}, {32'hCAFE_0000 + 32'(i), 32'h0}, 1'b1);
      #1;
      chk("locked_stall", rd_ready[1], 2'b00);
      step();
    end
    set_in(2'b01, {5'd0, 5'd9}, 10'h0, 2'b00, 10'h0, 64'h0, 1'b0);
    step();
    chk("unlock_ack", dbg_lock_ack[1], 1'b0);
    #1;
    chk("unlock_grant", rd_ready[1], 2'b01);
    step();

    // Reset in the cycle after a read grant
    set_in(2'b01, {5'd0, 5'd3}, 10'h0, 2'b00, 10'h0, 64'h0, 1'b0);
    step();
    do_reset();
    step();
    chk("post_rst_rsp", rsp_valid[1], 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rd_valid = 2'($urandom);
      wr_valid = 2'($urandom);
      rd_rs1   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rd_rs2   = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 3))};
      wr_rd    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      wr_data  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) dbg_lock = ~dbg_lock;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/risc_regfile_arbiter.md
RISC_REGFILE_ARBITER -- requirements
Module: risc_regfile_arbiter

Interface
REQ-001 The block SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding when nonzero.
REQ-002 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rd_valid  input  2  read request per requester; bit0 core, bit1 debug.
REQ-006 rd_ready  output  2  read grant per requester (combinational).
REQ-007 rd_rs1  input  10  packed rs1 indices; [4:0] core, [9:5] debug.
REQ-008 rd_rs2  input  10  packed rs2 indices; same packing.
REQ-009 wr_valid  input  2  write request per requester.
REQ-010 wr_ready  output  2  write grant per requester (combinational).
REQ-011 wr_rd  input  10  packed destination indices.
REQ-012 wr_data  input  64  packed write data; [31:0] core, [63:32] debug.
REQ-013 rsp_valid  output  1  read response valid.
REQ-014 rsp_id  output  1  response owner; 0 core, 1 debug.
REQ-015 rsp_rs1_data  output  32  rs1 read result.
REQ-016 rsp_rs2_data  output  32  rs2 read result.
REQ-017 dbg_lock  input  1  debug requests exclusive access.
REQ-018 dbg_lock_ack  output  1  exclusive access held by debug.
REQ-019 rf_rs1, rf_rs2, rf_rd  output  5 each  register-file indices.
REQ-020 rf_read_enable, rf_write_enable  output  1 each  register-file strobes.
REQ-021 rf_rd_data  output  32  register-file write data.
REQ-022 rf_rs1_data, rf_rs2_data  input  32 each  register-file read data, valid one cycle after rf_read_enable.

Function
REQ-023 Transfer SHALL occur when valid and ready are both high; requesters hold valid and payload until they are granted.
REQ-024 At most one read grant and at most one write grant SHALL be issued per cycle; read and write arbitration are independent.
REQ-025 Each port SHALL use round-robin arbitration with a 1-bit pointer: on contention the pointed requester wins, and the pointer moves to the other requester after any grant on that port.
REQ-026 A read grant SHALL drive rf_rs1/rf_rs2 from the winner and pulse rf_read_enable the same cycle; rsp_valid/rsp_id SHALL assert exactly one cycle later for one cycle, with no response backpressure.
REQ-027 A write grant SHALL drive rf_rd/rf_rd_data from the winner and pulse rf_write_enable the same cycle, except that rd=0 is accepted with rf_write_enable held low.
REQ-028 With BYPASS=1, a read and write granted in the same cycle with a matching nonzero index SHALL return the write data for that operand.
REQ-029 Any read operand with index 0 SHALL return 32'h0.
REQ-030 The lock FSM SHALL have states NORMAL, DRAIN and LOCKED.
REQ-031 NORMAL->DRAIN on dbg_lock=1; the core has no new grants in DRAIN or LOCKED.
REQ-032 DRAIN->LOCKED in the first cycle with no read response outstanding; dbg_lock_ack=1 exactly in LOCKED.
REQ-033 DRAIN or LOCKED SHALL return to NORMAL on dbg_lock=0, with dbg_lock_ack low the next cycle.
REQ-034 A core grant in the same cycle dbg_lock rises SHALL complete normally.
REQ-035 Debug requests SHALL be served in all three FSM states.

Reset
REQ-036 While rst_n=0 the block SHALL hold rsp_valid=0, rsp_id=0, dbg_lock_ack=0, FSM=NORMAL, both round-robin pointers=core, and all rf strobes low; any in-flight response is discarded.
REQ-037 rsp data outputs SHALL be don't-care while rsp_valid=0.

Structure
REQ-038 A shared package SHALL hold the FSM state encodings, the requester index constants (CORE=0, DBG=1) and the register index width (5).
REQ-039 One sub-module, rr_arb2 (2-way round-robin arbiter with pointer), SHALL be instantiated twice, once for reads and once for writes.

Verification
REQ-040 Both read requesters valid for 4 cycles, pointer=core -> grants alternate core, debug, core, debug, and rsp_id follows the same order one cycle later.
REQ-041 Core writes x5=32'hDEADBEEF while debug reads rs1=5 in the same cycle -> rsp_rs1_data=32'hDEADBEEF with BYPASS=1, and the old value with BYPASS=0.
REQ-042 Core writes x0=32'h1234 -> rf_write_enable stays 0, and a later read of x0 returns 0.
REQ-043 dbg_lock rises in the cycle a core read is granted -> response delivered, dbg_lock_ack rises two cycles later, core is stalled until dbg_lock falls.
REQ-044 rst_n pulled low in the cycle after a read grant -> no rsp_valid pulse, and state returns to its reset values.
